// File: rtl/serial_load_ctrl.sv
// Serial-to-parallel word assembler with optional even-parity check.
// Emits each good word on d_out with a one-cycle enb load pulse.
module serial_load_ctrl #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned PARITY_EN = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sin,
   input  logic             sin_vld,
   input  logic             frame,
   output logic [WIDTH-1:0] d_out,
   output logic             enb,
   output logic             par_err,
   output logic             busy
);

   localparam int unsigned   CntW    = $clog2(WIDTH) + 1;
   localparam logic [CntW-1:0] LastIdx = CntW'(WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StShift, StParity} state_t;

   state_t           state;
   logic [CntW-1:0]  cnt;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] word;

   // Bits above cnt are always zero while assembling, so OR-in places the new bit.
   always_comb word = shreg | (WIDTH'(sin) << cnt);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= StIdle;
         cnt     <= '0;
         shreg   <= '0;
         d_out   <= '0;
         enb     <= 1'b0;
         par_err <= 1'b0;
         busy    <= 1'b0;
      end else begin
         enb     <= 1'b0;
         par_err <= 1'b0;
         if (sin_vld) begin
            if (frame) begin
               // A framed bit always starts a fresh word, aborting any partial one.
               shreg <= WIDTH'(sin);
               cnt   <= CntW'(1);
               state <= StShift;
               busy  <= 1'b1;
            end else begin
               case (state)
                  StShift: begin
                     shreg <= word;
                     cnt   <= cnt + CntW'(1);
                     if (cnt == LastIdx) begin
                        if (PARITY_EN != 0) begin
                           state <= StParity;
                        end else begin
                           d_out <= word;
                           enb   <= 1'b1;
                           cnt   <= '0;
                           state <= StIdle;
                           busy  <= 1'b0;
                        end
                     end
                  end
                  StParity: begin
                     if ((^shreg) == sin) begin
                        d_out <= shreg;
                        enb   <= 1'b1;
                     end else begin
                        par_err <= 1'b1;
                     end
                     cnt   <= '0;
                     state <= StIdle;
                     busy  <= 1'b0;
                  end
                  default: ;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_serial_load_ctrl.sv
// Bench for serial_load_ctrl: one instance with parity, one without, shared stimulus,
// each checked per cycle against a bit-queue reference model.
module tb_serial_load_ctrl;

   localparam int unsigned W = 8;

   logic clk = 1'b0;
   logic rst, sin, sin_vld, frame;
   logic [W-1:0] d_out1, d_out0;
   logic enb1, enb0, par_err1, par_err0, busy1, busy0;
   logic [W+2:0] obs [2];

   int n_assert = 0;
   int n_fail   = 0;

   logic [2:0] stim [$];          // {sin, sin_vld, frame}
   bit         m_bits [2][$];     // accepted bits of the word in progress
   bit         m_act  [2];
   logic [W-1:0] m_d  [2];
   logic       m_enb  [2];
   logic       m_perr [2];
   logic [W+2:0] want [2];

   serial_load_ctrl #(.WIDTH(W), .PARITY_EN(1)) u_dut_par (
      .clk(clk), .rst(rst), .sin(sin), .sin_vld(sin_vld), .frame(frame),
      .d_out(d_out1), .enb(enb1), .par_err(par_err1), .busy(busy1)
   );

   serial_load_ctrl #(.WIDTH(W), .PARITY_EN(0)) u_dut_nopar (
      .clk(clk), .rst(rst), .sin(sin), .sin_vld(sin_vld), .frame(frame),
      .d_out(d_out0), .enb(enb0), .par_err(par_err0), .busy(busy0)
   );

   assign obs[1] = {d_out1, enb1, par_err1, busy1};
   assign obs[0] = {d_out0, enb0, par_err0, busy0};

   always #5 clk = ~clk;

   task automatic model_reset();
      for (int c = 0; c < 2; c++) begin
         m_bits[c].delete();
         m_act[c]  = 1'b0;
         m_d[c]    = '0;
         m_enb[c]  = 1'b0;
         m_perr[c] = 1'b0;
         want[c]   = '0;
      end
   endtask

   // Index c doubles as the parity-bit count of that configuration.
   task automatic model_step(input logic s, input logic v, input logic f);
      int word, ones;
      for (int c = 0; c < 2; c++) begin
         m_enb[c]  = 1'b0;
         m_perr[c] = 1'b0;
         if (v) begin
            if (f) begin
               m_bits[c].delete();
               m_bits[c].push_back(s);
               m_act[c] = 1'b1;
            end else if (m_act[c]) begin
               m_bits[c].push_back(s);
               if (m_bits[c].size() == W + c) begin
                  word = 0;
                  ones = 0;
                  for (int i = 0; i < m_bits[c].size(); i++) begin
                     if (i < W) word += int'(m_bits[c][i]) << i;
                     ones += int'(m_bits[c][i]);
                  end
                  if (c == 0 || ones % 2 == 0) begin
                     m_d[c]   = word[W-1:0];
                     m_enb[c] = 1'b1;
                  end else begin
                     m_perr[c] = 1'b1;
                  end
                  m_act[c] = 1'b0;
                  m_bits[c].delete();
               end
            end
         end
         want[c] = {m_d[c], m_enb[c], m_perr[c], m_act[c]};
      end
   endtask

   task automatic cycle(input logic [2:0] e);
      {sin, sin_vld, frame} = e;
      @(posedge clk);
      model_step(e[2], e[1], e[0]);
      #1;
   endtask

   task automatic add_bit(input logic s, input logic v, input logic f);
      stim.push_back({s, v, f});
   endtask

   // mode: 0 no parity bit, 1 correct even parity, 2 wrong parity
   task automatic add_word(input logic [W-1:0] w, input int nbits, input int mode,
                           input int gap_mask, input int gap_len);
      for (int i = 0; i < nbits; i++) begin
         add_bit(w[i], 1'b1, i == 0);
         if (gap_mask[i])
            for (int g = 0; g < gap_len; g++) add_bit(1'($urandom), 1'b0, 1'($urandom));
      end
      if (mode == 1) add_bit(^w, 1'b1, 1'b0);
      else if (mode == 2) add_bit(~^w, 1'b1, 1'b0);
   endtask

   task automatic test_reset();
      int k;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      for (int c = 0; c < 2; c++) begin
         n_assert++;
         if (obs[c] !== '0) begin
            n_fail++;
            $display("FAIL reset_state par%0d: got %h want 0", c, obs[c]);
         end
      end
      add_word(8'hC3, W, 1, 0, 0);
      add_word(8'h5E, 3, 0, 0, 0);
      k = 0;
      while (stim.size() > 0) begin
         cycle(stim.pop_front());
         for (int c = 0; c < 2; c++) begin
            n_assert++;
            if (obs[c] !== want[c]) begin
               n_fail++;
               $display("FAIL pre_reset par%0d cyc %0d: got %h want %h", c, k, obs[c], want[c]);
            end
         end
         k++;
      end
      #2 rst = 1'b1;
      #1;
      for (int c = 0; c < 2; c++) begin
         n_assert++;
         if (obs[c] !== '0) begin
            n_fail++;
            $display("FAIL async_reset par%0d: got %h want 0", c, obs[c]);
         end
      end
      model_reset();
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (5) add_bit(1'($urandom), 1'b1, 1'b0);
      k = 0;
      while (stim.size() > 0) begin
         cycle(stim.pop_front());
         for (int c = 0; c < 2; c++) begin
            n_assert++;
            if (obs[c] !== want[c]) begin
               n_fail++;
               $display("FAIL unframed par%0d cyc %0d: got %h want %h", c, k, obs[c], want[c]);
            end
         end
         k++;
      end
   endtask

   task automatic test_good_word();
      int k, enb_at, n_perr;
      logic [W-1:0] got_d;
      add_word(8'hA5, W, 1, 0, 0);
      add_bit(1'b0, 1'b0, 1'b0);
      k = 0; enb_at = -1; n_perr = 0; got_d = '0;
      while (stim.size() > 0) begin
         cycle(stim.pop_front());
         for (int c = 0; c < 2; c++) begin
            n_assert++;
            if (obs[c] !== want[c]) begin
               n_fail++;
               $display("FAIL good_word par%0d cyc %0d: got %h want %h", c, k, obs[c], want[c]);
            end
         end
         if (enb1 && enb_at < 0) begin enb_at = k; got_d = d_out1; end
         if (par_err1) n_perr++;
         k++;
      end
      n_assert++;
      if (enb_at != 8 || got_d !== 8'hA5 || n_perr != 0) begin
         n_fail++;
         $display("FAIL good_word_load: got enb_at=%0d d_out=%h par_err=%0d want 8 a5 0",
                  enb_at, got_d, n_perr);
      end
   endtask

   task automatic test_parity_error();
      int k, n_enb, n_perr;
      add_word(8'h07, W, 2, 0, 0);
      add_bit(1'b0, 1'b0, 1'b0);
      k = 0; n_enb = 0; n_perr = 0;
      while (stim.size() > 0) begin
         cycle(stim.pop_front());
         for (int c = 0; c < 2; c++) begin
            n_assert++;
            if (obs[c] !== want[c]) begin
               n_fail++;
               $display("FAIL parity_err par%0d cyc %0d: got %h want %h", c, k, obs[c], want[c]);
            end
         end
         if (enb1) n_enb++;
         if (par_err1) n_perr++;
         k++;
      end
      n_assert++;
      if (n_enb != 0 || n_perr != 1 || d_out1 !== 8'hA5) begin
         n_fail++;
         $display("FAIL parity_err_pulse: got enb=%0d par_err=%0d d_out=%h want 0 1 a5",
                  n_enb, n_perr, d_out1);
      end
   endtask

   task automatic test_gaps();
      int k, enb_at, gap_bad;
      logic [2:0] e;
      logic [W-1:0] got_d;
      add_word(8'h3C, W, 1, (1 << 2) | (1 << 6), 3);
      add_bit(1'b0, 1'b0, 1'b0);
      k = 0; enb_at = -1; gap_bad = 0; got_d = '0;
      while (stim.size() > 0) begin
         e = stim.pop_front();
         cycle(e);
         for (int c = 0; c < 2; c++) begin
            n_assert++;
            if (obs[c] !== want[c]) begin
               n_fail++;
               $display("FAIL gaps par%0d cyc %0d: got %h want %h", c, k, obs[c], want[c]);
            end
         end
         if (!e[1] && k < 14 && busy1 !== 1'b1) gap_bad++;
         if (enb1 && enb_at < 0) begin enb_at = k; got_d = d_out1; end
         k++;
      end
      n_assert++;
      if (enb_at != 14 || got_d !== 8'h3C || gap_bad != 0) begin
         n_fail++;
         $display("FAIL gaps_load: got enb_at=%0d d_out=%h idle_gaps=%0d want 14 3c 0",
                  enb_at, got_d, gap_bad);
      end
   endtask

   task automatic test_resync_b2b();
      int k, n_perr;
      logic [W-1:0] loads [$];
      add_word(8'h96, 4, 0, 0, 0);
      add_word(8'h5A, W, 1, 0, 0);
      add_word(8'hFF, W, 1, 0, 0);
      add_bit(1'b0, 1'b0, 1'b0);
      add_bit(1'b0, 1'b0, 1'b0);
      k = 0; n_perr = 0;
      while (stim.size() > 0) begin
         cycle(stim.pop_front());
         for (int c = 0; c < 2; c++) begin
            n_assert++;
            if (obs[c] !== want[c]) begin
               n_fail++;
               $display("FAIL resync_b2b par%0d cyc %0d: got %h want %h", c, k, obs[c], want[c]);
            end
         end
         if (enb1) loads.push_back(d_out1);
         if (par_err1) n_perr++;
         k++;
      end
      n_assert++;
      if (loads.size() != 2 || loads[0] !== 8'h5A || loads[1] !== 8'hFF || n_perr != 0) begin
         n_fail++;
         $display("FAIL resync_b2b_loads: got n=%0d first=%h second=%h par_err=%0d want 2 5a ff 0",
                  loads.size(), loads[0], loads[1], n_perr);
      end
   endtask

   task automatic test_reset_midword();
      int k, n_enb, enb_at;
      logic [W-1:0] got_d;
      add_word(8'hE7, 4, 0, 0, 0);
      k = 0;
      while (stim.size() > 0) begin
         cycle(stim.pop_front());
         for (int c = 0; c < 2; c++) begin
            n_assert++;
            if (obs[c] !== want[c]) begin
               n_fail++;
               $display("FAIL partial par%0d cyc %0d: got %h want %h", c, k, obs[c], want[c]);
            end
         end
         k++;
      end
      #2 rst = 1'b1;
      model_reset();
      @(posedge clk);
      #1 rst = 1'b0;
      add_word(8'h81, W, 1, 0, 0);
      add_bit(1'b0, 1'b0, 1'b0);
      k = 0; n_enb = 0; got_d = '0;
      while (stim.size() > 0) begin
         cycle(stim.pop_front());
         for (int c = 0; c < 2; c++) begin
            n_assert++;
            if (obs[c] !== want[c]) begin
               n_fail++;
               $display("FAIL after_reset par%0d cyc %0d: got %h want %h", c, k, obs[c], want[c]);
            end
         end
         if (enb1) begin n_enb++; got_d = d_out1; end
         k++;
      end
      n_assert++;
      if (n_enb != 1 || got_d !== 8'h81) begin
         n_fail++;
         $display("FAIL after_reset_load: got enb=%0d d_out=%h want 1 81", n_enb, got_d);
      end
      add_word(8'h81, W, 0, 0, 0);
      add_bit(1'b0, 1'b0, 1'b0);
      k = 0; enb_at = -1; got_d = '0;
      while (stim.size() > 0) begin
         cycle(stim.pop_front());
         for (int c = 0; c < 2; c++) begin
            n_assert++;
            if (obs[c] !== want[c]) begin
               n_fail++;
               $display("FAIL nopar_word par%0d cyc %0d: got %h want %h", c, k, obs[c], want[c]);
            end
         end
         if (enb0 && enb_at < 0) begin enb_at = k; got_d = d_out0; end
         k++;
      end
      n_assert++;
      if (enb_at != 7 || got_d !== 8'h81) begin
         n_fail++;
         $display("FAIL nopar_load: got enb_at=%0d d_out=%h want 7 81", enb_at, got_d);
      end
   endtask

   task automatic test_random();
      int k, r;
      for (int n = 0; n < 200; n++) begin
         r = $urandom_range(0, 9);
         if (r < 2) begin
            repeat ($urandom_range(1, 3)) add_bit(1'($urandom), 1'($urandom), 1'($urandom));
         end else if (r == 2) begin
            add_word(W'($urandom), $urandom_range(1, W - 1), 0, 0, 0);
         end else begin
            add_word(W'($urandom), W, $urandom_range(0, 2),
                     int'($urandom & $urandom & $urandom), $urandom_range(1, 3));
         end
      end
      repeat (3) add_bit(1'b0, 1'b0, 1'b0);
      k = 0;
      while (stim.size() > 0) begin
         cycle(stim.pop_front());
         for (int c = 0; c < 2; c++) begin
            n_assert++;
            if (obs[c] !== want[c]) begin
               n_fail++;
               $display("FAIL random par%0d cyc %0d: got %h want %h", c, k, obs[c], want[c]);
            end
         end
         k++;
      end
   endtask

   initial begin
      rst = 1'b1;
      sin = 1'b0;
      sin_vld = 1'b0;
      frame = 1'b0;
      model_reset();
      test_reset();
      test_good_word();
      test_parity_error();
      test_gaps();
      test_resync_b2b();
      test_reset_midword();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
